// File: rtl/redirect_sched.sv
// redirect_sched: fetch-redirect sequencer.
// This block counts the conditional branches that are still unresolved and
// decides when the PC is redirected. A taken branch always wins over a
// JAL/JALR. A JAL/JALR waits until every older branch has resolved and its
// rs operand is ready. Each redirect produces a one-cycle pc_load, followed
// by a fixed flush window of FLUSH_CYCLES cycles.
module redirect_sched #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_PEND     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_branch,
    input  logic        issue_jal,
    input  logic [31:0] jal_target,
    input  logic        jal_rs_ready,
    input  logic        br_resolve,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        flush,
    output logic        stall_decode,
    output logic [2:0]  pend_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        JAL_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] MAX_P      = 3'(MAX_PEND);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [2:0]  pend_reg, pend_next;
    logic [3:0]  fcnt_reg, fcnt_next;
    logic        pc_load_reg, pc_load_next;
    logic        flush_reg, flush_next;
    logic [31:0] target_reg, target_next;
    logic        stall_next;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        taken;
    logic        nt_dec;

    // A taken resolve is always the oldest event. A not-taken resolve only
    // decrements the count when a branch is actually outstanding.
    assign taken  = br_resolve && br_taken;
    assign nt_dec = br_resolve && !br_taken && (pend_reg != 3'd0);

    // Next-state, branch accounting and redirect selection
    always_comb begin
        state_next    = state_reg;
        pend_next     = pend_reg;
        fcnt_next     = fcnt_reg;
        pc_load_next  = 1'b0;
        flush_next    = flush_reg;
        target_next   = target_reg;
        stall_next    = 1'b0;
        redirect      = 1'b0;
        redirect_addr = target_reg;
        case (state_reg)
            RUN: begin
                if (taken) begin
                    // Every branch younger than the taken one is discarded.
                    redirect      = 1'b1;
                    redirect_addr = br_target;
                    pend_next     = 3'd0;
                end else begin
                    if (issue_jal) begin
                        if (pend_reg == 3'd0 && jal_rs_ready) begin
                            redirect      = 1'b1;
                            redirect_addr = jal_target;
                        end else begin
                            state_next = JAL_WAIT;
                            stall_next = 1'b1;
                        end
                    end
                    if (issue_branch) begin
                        // A same-cycle resolve frees the slot the new branch uses.
                        if (nt_dec) begin
                            pend_next = pend_reg;
                        end else if (pend_reg == MAX_P) begin
                            stall_next = 1'b1;
                        end else begin
                            pend_next = pend_reg + 3'd1;
                        end
                    end else if (nt_dec) begin
                        pend_next = pend_reg - 3'd1;
                    end
                end
            end
            JAL_WAIT: begin
                stall_next = 1'b1;
                if (taken) begin
                    // The waiting JAL is younger than the branch, so it is dropped.
                    redirect      = 1'b1;
                    redirect_addr = br_target;
                    pend_next     = 3'd0;
                end else if (pend_reg == 3'd0 && jal_rs_ready) begin
                    redirect      = 1'b1;
                    redirect_addr = jal_target;
                end else if (nt_dec) begin
                    pend_next = pend_reg - 3'd1;
                end
            end
            FLUSH: begin
                if (fcnt_reg == 4'd0) begin
                    flush_next = 1'b0;
                    state_next = RUN;
                end else begin
                    fcnt_next = fcnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (redirect) begin
            pc_load_next = 1'b1;
            target_next  = redirect_addr;
            flush_next   = 1'b1;
            fcnt_next    = FLUSH_LAST;
            state_next   = FLUSH;
        end
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            pend_reg    <= 3'd0;
            fcnt_reg    <= 4'd0;
            pc_load_reg <= 1'b0;
            flush_reg   <= 1'b0;
            target_reg  <= 32'd0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            fcnt_reg    <= fcnt_next;
            pc_load_reg <= pc_load_next;
            flush_reg   <= flush_next;
            target_reg  <= target_next;
        end
    end

    assign stall_decode = stall_next && !reset;
    assign pc_load      = pc_load_reg;
    assign pc_target    = target_reg;
    assign flush        = flush_reg;
    assign pend_cnt     = pend_reg;
    assign state        = state_reg;

endmodule
